// File: rtl/uart_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_fifo_if
// Peripheral-bus bundle for the UART block. Writes and reads complete in one
// cycle; rd_data_o is combinational from rd_addr_i.
//   wr_en_i   : write strobe
//   wr_addr_i : write address (only [7:0] decoded by the slave)
//   wr_data_i : write data
//   rd_en_i   : read strobe (pops RXDATA when addressed)
//   rd_addr_i : read address (only [7:0] decoded by the slave)
//   rd_data_o : read data
// Modports: master (bus initiator), slave (the UART).
// -----------------------------------------------------------------------------
interface uart_fifo_if #(
    parameter int ADDR_W = 32
);
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [31:0]       wr_data_i;
    logic              rd_en_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [31:0]       rd_data_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
        input  rd_data_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
        output rd_data_o
    );
endinterface

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// Memory-mapped UART with TX/RX FIFOs, run-time data width, parity and stop
// bit count, sticky error flags and a registered level interrupt.
//   clk_i    : clock
//   rst_n_i  : asynchronous active-low reset
//   uart_rx  : serial input (asynchronous, synchronised internally)
//   uart_tx  : serial output, idle high (registered)
//   bus      : peripheral bus slave port (see uart_fifo_if)
//   irq_o    : level interrupt
// Register map: 0x00 CTRL, 0x04 STATUS, 0x08 BAUD, 0x0C TXDATA, 0x10 RXDATA.
// -----------------------------------------------------------------------------
module uart_fifo #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int BAUD_RST = 434,
    parameter int ADDR_W   = 32
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           uart_rx,
    output logic           uart_tx,
    uart_fifo_if.slave     bus,
    output logic           irq_o
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_ONE    = 1;
    localparam logic [RX_AW:0] RX_ONE    = 1;
    localparam logic [3:0]     DBITS_MAX = 4'(DATA_W);

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_BAUD   = 8'h08;
    localparam logic [7:0] A_TXDATA = 8'h0C;
    localparam logic [7:0] A_RXDATA = 8'h10;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    // Frame settings captured at frame start so register writes only affect
    // the next frame.
    typedef struct packed {
        logic [15:0] baud;
        logic [3:0]  dbits;
        logic        par_en;
        logic        par_odd;
        logic        two_stop;
    } cfg_t;

    // Parity bit that makes the frame even (odd=0) or odd (odd=1); bits at or
    // above n are not part of the frame.
    function automatic logic calc_par(input logic [DATA_W-1:0] w,
                                      input logic [3:0] n, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(n)) p = p ^ w[i];
        end
        return p;
    endfunction

    // ---------------- registers ----------------
    logic [10:0] ctrl_q, ctrl_d;
    logic [15:0] baud_q, baud_d;
    logic        overrun_q, overrun_d, parity_err_q, parity_err_d;
    logic        frame_err_q, frame_err_d, irq_q, irq_d;

    logic [TX_AW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [RX_AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];

    state_e            tx_state_q, tx_state_d;
    logic [15:0]       tx_cnt_q, tx_cnt_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_par_q, tx_par_d, tx_stop2_q, tx_stop2_d;
    logic              tx_line_q, tx_line_d;
    cfg_t              tx_cfg_q, tx_cfg_d;

    state_e            rx_state_q, rx_state_d;
    logic [15:0]       rx_cnt_q, rx_cnt_d;
    logic [3:0]        rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [2:0]        rx_sync_q, rx_sync_d;
    cfg_t              rx_cfg_q, rx_cfg_d;

    // ---------------- decode / config ----------------
    logic wr_ctrl, wr_status, wr_baud, wr_tx;
    cfg_t cur_cfg;

    assign wr_ctrl   = bus.wr_en_i && (bus.wr_addr_i[7:0] == A_CTRL);
    assign wr_status = bus.wr_en_i && (bus.wr_addr_i[7:0] == A_STATUS);
    assign wr_baud   = bus.wr_en_i && (bus.wr_addr_i[7:0] == A_BAUD);
    assign wr_tx     = bus.wr_en_i && (bus.wr_addr_i[7:0] == A_TXDATA);

    always_comb begin
        cur_cfg.baud     = (baud_q < 16'd4) ? 16'd4 : baud_q;
        cur_cfg.dbits    = (ctrl_q[8:5] >= 4'd5 && ctrl_q[8:5] <= DBITS_MAX) ? ctrl_q[8:5] : DBITS_MAX;
        cur_cfg.par_en   = ctrl_q[3] ^ ctrl_q[2];   // 01 even, 10 odd
        cur_cfg.par_odd  = ctrl_q[3];
        cur_cfg.two_stop = ctrl_q[4];
    end

    // ---------------- FIFO status ----------------
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic [DATA_W-1:0] tx_head, rx_head;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                      (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                      (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
    assign tx_head  = tx_mem[tx_rptr_q[TX_AW-1:0]];
    assign rx_head  = rx_mem[rx_rptr_q[RX_AW-1:0]];

    logic tx_push, tx_pop, rx_pop, rx_push_req, rx_push, rx_ovr_set;
    logic rx_set_par, rx_set_frm;

    assign tx_push    = wr_tx && !tx_full;
    assign rx_pop     = bus.rd_en_i && (bus.rd_addr_i[7:0] == A_RXDATA) && !rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign rx_push    = rx_push_req && (!rx_full || rx_pop);
    assign rx_ovr_set = rx_push_req && rx_full && !rx_pop;

    // ---------------- TX FSM ----------------
    logic tx_bit_end, tx_load;
    assign tx_bit_end = (tx_cnt_q == tx_cfg_q.baud - 16'd1);

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; that is what keeps a latch from being inferred.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_bit_end ? 16'd0 : tx_cnt_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_stop2_d = tx_stop2_q;
        tx_cfg_d   = tx_cfg_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = 16'd0;
                if (ctrl_q[0] && !tx_empty) tx_load = 1'b1;
            end
            S_START: if (tx_bit_end) begin
                tx_state_d = S_DATA;
                tx_bit_d   = 4'd0;
            end
            S_DATA: if (tx_bit_end) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = tx_bit_q + 4'd1;
                tx_stop2_d = 1'b0;
                if (tx_bit_q == tx_cfg_q.dbits - 4'd1)
                    tx_state_d = tx_cfg_q.par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: if (tx_bit_end) begin
                tx_state_d = S_STOP;
                tx_stop2_d = 1'b0;
            end
            S_STOP: if (tx_bit_end) begin
                if (tx_cfg_q.two_stop && !tx_stop2_q) tx_stop2_d = 1'b1;
                else if (ctrl_q[0] && !tx_empty)      tx_load    = 1'b1;  // back-to-back
                else                                  tx_state_d = S_IDLE;
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = S_START;
            tx_cnt_d   = 16'd0;
            tx_cfg_d   = cur_cfg;
            tx_shift_d = tx_head;
            tx_par_d   = calc_par(tx_head, cur_cfg.dbits, cur_cfg.par_odd);
            tx_stop2_d = 1'b0;
        end
    end

    // Line is registered from the state, giving a glitch-free output one
    // cycle behind the FSM.
    always_comb begin
        case (tx_state_q)
            S_START:  tx_line_d = 1'b0;
            S_DATA:   tx_line_d = tx_shift_q[0];
            S_PARITY: tx_line_d = tx_par_q;
            default:  tx_line_d = 1'b1;
        endcase
    end

    // ---------------- RX FSM ----------------
    logic rx_s, rx_fall, rx_bit_end;
    logic [DATA_W-1:0] rx_word;

    assign rx_s       = rx_sync_q[1];
    assign rx_fall    = rx_sync_q[2] && !rx_sync_q[1];
    assign rx_bit_end = (rx_cnt_q == rx_cfg_q.baud - 16'd1);
    // Bits arrive at the MSB end; right-align for narrower frames.
    assign rx_word    = rx_shift_q >> (DBITS_MAX - rx_cfg_q.dbits);
    assign rx_sync_d  = {rx_sync_q[1:0], uart_rx};

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_bit_end ? 16'd0 : rx_cnt_q + 16'd1;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_cfg_d    = rx_cfg_q;
        rx_push_req = 1'b0;
        rx_set_par  = 1'b0;
        rx_set_frm  = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = 16'd0;
                if (rx_fall) begin
                    rx_state_d = S_START;
                    rx_cfg_d   = cur_cfg;
                    rx_shift_d = '0;
                end
            end
            S_START: if (rx_cnt_q == (rx_cfg_q.baud >> 1)) begin
                rx_cnt_d   = 16'd0;
                rx_bit_d   = 4'd0;
                rx_state_d = rx_s ? S_IDLE : S_DATA;   // high here = false start
            end
            S_DATA: if (rx_bit_end) begin
                rx_shift_d = {rx_s, rx_shift_q[DATA_W-1:1]};
                rx_bit_d   = rx_bit_q + 4'd1;
                if (rx_bit_q == rx_cfg_q.dbits - 4'd1)
                    rx_state_d = rx_cfg_q.par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: if (rx_bit_end) begin
                rx_set_par = (rx_s != calc_par(rx_word, rx_cfg_q.dbits, rx_cfg_q.par_odd));
                rx_state_d = S_STOP;
            end
            S_STOP: if (rx_bit_end) begin
                rx_push_req = 1'b1;
                rx_set_frm  = !rx_s;
                rx_state_d  = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
        if (!ctrl_q[1]) begin
            rx_state_d  = S_IDLE;
            rx_push_req = 1'b0;
            rx_set_par  = 1'b0;
            rx_set_frm  = 1'b0;
        end
    end

    // ---------------- registers / status ----------------
    logic [2:0] w1c;
    assign w1c = wr_status ? bus.wr_data_i[6:4] : 3'b000;

    always_comb begin
        ctrl_d       = wr_ctrl ? bus.wr_data_i[10:0] : ctrl_q;
        baud_d       = wr_baud ? bus.wr_data_i[15:0] : baud_q;
        // Hardware set has priority over a same-cycle W1C.
        overrun_d    = (overrun_q    & ~w1c[0]) | rx_ovr_set;
        parity_err_d = (parity_err_q & ~w1c[1]) | rx_set_par;
        frame_err_d  = (frame_err_q  & ~w1c[2]) | rx_set_frm;
        tx_wptr_d    = tx_push ? tx_wptr_q + TX_ONE : tx_wptr_q;
        tx_rptr_d    = tx_pop  ? tx_rptr_q + TX_ONE : tx_rptr_q;
        rx_wptr_d    = rx_push ? rx_wptr_q + RX_ONE : rx_wptr_q;
        rx_rptr_d    = rx_pop  ? rx_rptr_q + RX_ONE : rx_rptr_q;
        irq_d        = (ctrl_q[9] & !rx_empty) | (ctrl_q[10] & tx_empty) |
                       overrun_q | parity_err_q | frame_err_q;
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q       <= '0;
            baud_q       <= 16'(BAUD_RST);
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            irq_q        <= 1'b0;
            tx_wptr_q    <= '0;
            tx_rptr_q    <= '0;
            rx_wptr_q    <= '0;
            rx_rptr_q    <= '0;
            tx_state_q   <= S_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            tx_stop2_q   <= 1'b0;
            tx_line_q    <= 1'b1;
            tx_cfg_q     <= '0;
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_sync_q    <= 3'b111;
            rx_cfg_q     <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            baud_q       <= baud_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            irq_q        <= irq_d;
            tx_wptr_q    <= tx_wptr_d;
            tx_rptr_q    <= tx_rptr_d;
            rx_wptr_q    <= rx_wptr_d;
            rx_rptr_q    <= rx_rptr_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_q     <= tx_par_d;
            tx_stop2_q   <= tx_stop2_d;
            tx_line_q    <= tx_line_d;
            tx_cfg_q     <= tx_cfg_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_sync_q    <= rx_sync_d;
            rx_cfg_q     <= rx_cfg_d;
        end
    end

    // NOTE: FIFO storage has no reset; emptiness is defined by the pointers,
    // so stale contents are never observable.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wptr_q[TX_AW-1:0]] <= bus.wr_data_i[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wptr_q[RX_AW-1:0]] <= rx_word;
    end

    // ---------------- outputs ----------------
    logic [7:0] status;
    assign status = {tx_state_q != S_IDLE, frame_err_q, parity_err_q, overrun_q,
                     rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        case (bus.rd_addr_i[7:0])
            A_CTRL:   bus.rd_data_o = {21'd0, ctrl_q};
            A_STATUS: bus.rd_data_o = {24'd0, status};
            A_BAUD:   bus.rd_data_o = {16'd0, baud_q};
            A_RXDATA: bus.rd_data_o = rx_empty ? 32'd0 : {{(32-DATA_W){1'b0}}, rx_head};
            default:  bus.rd_data_o = 32'd0;
        endcase
    end

    assign uart_tx = tx_line_q;
    assign irq_o   = irq_q;

    // Address bits above [7:0], upper write data and unused latched fields.
    logic unused_bits;
    assign unused_bits = ^{bus.wr_addr_i[ADDR_W-1:8], bus.rd_addr_i[ADDR_W-1:8],
                           bus.wr_data_i[31:16], tx_cfg_q.par_odd, rx_cfg_q.two_stop};

endmodule

// File: tb/tb_uart_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo
// Directed bench for uart_fifo: reset state, TX timing, loopback with odd
// parity, TX FIFO full/drop, RX overrun/W1C, parity/frame errors, false
// start rejection and asynchronous reset mid-frame. Expected bytes go into a
// scoreboard queue when driven and are compared when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_uart_fifo;

    localparam int          BAUD     = 16;
    localparam logic [7:0]  A_CTRL   = 8'h00;
    localparam logic [7:0]  A_STATUS = 8'h04;
    localparam logic [7:0]  A_BAUD   = 8'h08;
    localparam logic [7:0]  A_TXDATA = 8'h0C;
    localparam logic [7:0]  A_RXDATA = 8'h10;

    logic clk_i = 1'b0;
    logic rst_n_i;
    logic uart_tx, irq_o, rx_line;
    logic rx_drv  = 1'b1;
    logic loop_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    uart_fifo_if #(.ADDR_W(32)) bus ();

    assign rx_line = loop_en ? uart_tx : rx_drv;

    uart_fifo dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .uart_rx (rx_line),
        .uart_tx (uart_tx),
        .bus     (bus),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_i);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = {24'd0, a};
        bus.wr_data_i = d;
        @(negedge clk_i);
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk_i);
        bus.rd_en_i   = 1'b0;
        bus.rd_addr_i = {24'd0, a};
        #1 d = bus.rd_data_o;
    endtask

    task automatic pop(output logic [31:0] d);
        @(negedge clk_i);
        bus.rd_addr_i = {24'd0, A_RXDATA};
        bus.rd_en_i   = 1'b1;
        #1 d = bus.rd_data_o;
        @(negedge clk_i);
        bus.rd_en_i   = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk_i);
        rx_drv = b;
        repeat (BAUD - 1) @(negedge clk_i);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par_bit);
        drive_bit(stop_bit);
        rx_drv = 1'b1;
    endtask

    // Decode one 8N1 frame from uart_tx; ok=0 if no start within budget or
    // the stop bit is low.
    task automatic capture_tx(output logic [7:0] d, output logic ok);
        int budget;
        budget = 0;
        ok = 1'b0;
        d  = '0;
        while (uart_tx !== 1'b0 && budget < 2000) begin
            @(negedge clk_i);
            budget++;
        end
        if (uart_tx === 1'b0) begin
            repeat (BAUD / 2) @(negedge clk_i);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk_i);
                d[i] = uart_tx;
            end
            repeat (BAUD) @(negedge clk_i);
            ok = (uart_tx === 1'b1);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        logic        ok;
        logic        quiet;

        rst_n_i       = 1'b0;
        bus.wr_en_i   = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        bus.rd_en_i   = 1'b0;
        bus.rd_addr_i = '0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;

        // ---- reset state ----
        check("rst_uart_tx", uart_tx, 1);
        check("rst_irq", irq_o, 0);
        rd(A_STATUS, r); check("rst_status", r, 32'h06);
        rd(A_CTRL, r);   check("rst_ctrl", r, 0);
        rd(A_BAUD, r);   check("rst_baud", r, 32'd434);

        // ---- 1: TX timing, 0xA5 8N1 ----
        wr(A_BAUD, BAUD);
        wr(A_CTRL, 32'h101);
        bus.rd_addr_i = {24'd0, A_STATUS};
        wr(A_TXDATA, 32'hA5);
        exp_q.push_back(8'hA5);
        @(negedge clk_i); check("t1_tx_edge_n1", uart_tx, 1);
        @(negedge clk_i); check("t1_tx_edge_n2", uart_tx, 0);
        repeat (BAUD / 2) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge clk_i);
            b[i] = uart_tx;
        end
        check("t1_byte", b, exp_q.pop_front());
        repeat (BAUD) @(negedge clk_i); check("t1_stop", uart_tx, 1);
        repeat (6) @(negedge clk_i);    check("t1_busy_160", bus.rd_data_o[7], 1);
        @(negedge clk_i);               check("t1_busy_161", bus.rd_data_o[7], 0);

        // ---- 2: loopback, odd parity, 2 stop bits ----
        wr(A_CTRL, 0);
        loop_en = 1'b1;
        wr(A_CTRL, 32'h11B);
        wr(A_TXDATA, 32'h00); exp_q.push_back(8'h00);
        wr(A_TXDATA, 32'hFF); exp_q.push_back(8'hFF);
        wr(A_TXDATA, 32'h3C); exp_q.push_back(8'h3C);
        repeat (700) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            pop(r);
            check("t2_rxdata", r, {24'd0, exp_q.pop_front()});
        end
        rd(A_STATUS, r); check("t2_status", r, 32'h06);
        loop_en = 1'b0;

        // ---- 3: TX FIFO full, 17th dropped, then 16 frames ----
        wr(A_CTRL, 0);
        for (int i = 0; i < 17; i++) begin
            wr(A_TXDATA, 32'h30 + i);
            if (i < 16) exp_q.push_back(8'(8'h30 + i));
        end
        rd(A_STATUS, r); check("t3_full_status", r, 32'h05);
        wr(A_CTRL, 32'h101);
        for (int i = 0; i < 16; i++) begin
            capture_tx(b, ok);
            check("t3_frame_ok", ok, 1);
            check("t3_frame_data", b, exp_q.pop_front());
        end
        quiet = 1'b1;
        repeat (300) begin
            @(negedge clk_i);
            if (uart_tx !== 1'b1) quiet = 1'b0;
        end
        check("t3_no_extra_frame", quiet, 1);
        rd(A_STATUS, r); check("t3_drained_status", r, 32'h06);

        // ---- 4: RX overrun ----
        wr(A_CTRL, 32'h102);
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(8'h50 + i), 1'b0, 1'b0, 1'b1);
            if (i < 16) exp_q.push_back(8'(8'h50 + i));
            if (i == 15) begin
                rd(A_STATUS, r); check("t4_full_no_ovr", r, 32'h0A);
            end
        end
        repeat (3) @(negedge clk_i);
        rd(A_STATUS, r); check("t4_overrun_status", r, 32'h1A);
        check("t4_irq_set", irq_o, 1);
        for (int i = 0; i < 16; i++) begin
            pop(r);
            check("t4_rxdata", r, {24'd0, exp_q.pop_front()});
        end
        rd(A_STATUS, r); check("t4_empty_ovr", r, 32'h16);
        wr(A_STATUS, 32'h10);
        rd(A_STATUS, r); check("t4_w1c", r, 32'h06);
        repeat (2) @(negedge clk_i);
        check("t4_irq_clear", irq_o, 0);

        // ---- 5: even parity good/bad, frame error, glitch ----
        wr(A_CTRL, 32'h106);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);      // correct even parity
        exp_q.push_back(8'h5A);
        repeat (4) @(negedge clk_i);
        rd(A_STATUS, r); check("t5_good_status", r, 32'h02);
        pop(r); check("t5_good_data", r, {24'd0, exp_q.pop_front()});
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0);      // wrong parity, stop=0
        exp_q.push_back(8'hC3);
        repeat (4) @(negedge clk_i);
        rd(A_STATUS, r); check("t5_err_status", r, 32'h62);
        check("t5_err_irq", irq_o, 1);
        pop(r); check("t5_err_data", r, {24'd0, exp_q.pop_front()});
        wr(A_STATUS, 32'h60);
        rd(A_STATUS, r); check("t5_w1c", r, 32'h06);
        @(negedge clk_i); rx_drv = 1'b0;
        @(negedge clk_i); rx_drv = 1'b1;
        repeat (250) @(negedge clk_i);
        rd(A_STATUS, r); check("t5_glitch_ignored", r, 32'h06);

        // ---- 6: async reset mid TX data bit ----
        wr(A_CTRL, 32'h101);
        wr(A_TXDATA, 32'hA5);
        wr(A_TXDATA, 32'h3C);
        repeat (40) @(negedge clk_i);
        check("t6_pre_reset_low", uart_tx, 0);
        rst_n_i = 1'b0;
        bus.rd_addr_i = {24'd0, A_STATUS};
        #1;
        check("t6_tx_async_high", uart_tx, 1);
        check("t6_status_in_reset", bus.rd_data_o, 32'h06);
        check("t6_irq_in_reset", irq_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        rd(A_STATUS, r); check("t6_status", r, 32'h06);
        rd(A_CTRL, r);   check("t6_ctrl", r, 0);
        rd(A_BAUD, r);   check("t6_baud", r, 32'd434);
        rd(A_RXDATA, r); check("t6_rxdata_empty", r, 0);
        repeat (20) @(negedge clk_i);
        check("t6_tx_idle", uart_tx, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Parametrised memory-mapped UART peripheral. Replaces the single-byte UART with TX/RX FIFOs, run-time data width, parity and stop-bit count, sticky error flags and an interrupt output. Sits on the core peripheral bus; bus writes and reads complete in one cycle.

Parameters:
DATA_W, 8, maximum frame data bits (5..9); CTRL.dbits selects active count ≤ DATA_W
TX_DEPTH, 16, TX FIFO entries, power of two ≥ 2
RX_DEPTH, 16, RX FIFO entries, power of two ≥ 2
BAUD_RST, 434, reset value of BAUD (clocks per bit, CLK_FREQ/UART_BPS)
ADDR_W, 32, bus address width (only [7:0] decoded)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
uart_rx  in  1  serial input (asynchronous)
uart_tx  out  1  serial output, idle high
wr_en_i  in  1  write strobe
wr_addr_i  in  ADDR_W  write address
wr_data_i  in  32  write data
rd_en_i  in  1  read strobe (pops RXDATA)
rd_addr_i  in  ADDR_W  read address
rd_data_o  out  32  read data, combinational from rd_addr_i
irq_o  out  1  level interrupt

Behaviour:
- Reset (async, active-low): uart_tx=1, irq_o=0, FIFOs empty, CTRL=0, BAUD=BAUD_RST, status sticky bits 0, both FSMs IDLE. Reset mid-frame aborts the frame immediately.
- Map: 0x00 CTRL RW: [0] tx_en, [1] rx_en, [3:2] parity (00 none, 01 even, 10 odd, 11 = none), [4] two stop bits, [8:5] dbits (5..DATA_W, else DATA_W), [9] rxne_ie, [10] txe_ie.
- 0x04 STATUS: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] overrun, [5] parity_err, [6] frame_err, [7] tx_busy. Bits 4..6 sticky, W1C; others RO. Hardware set and W1C in the same cycle: set wins.
- 0x08 BAUD RW [15:0]. Values < 4 behave as 4. Latched at frame start; mid-frame writes affect the next frame only.
- 0x0C TXDATA WO. Write pushes wr_data_i[DATA_W-1:0]. Write when full is dropped with no flag.
- 0x10 RXDATA RO. rd_data_o = {zero-extend, FIFO head}, or 0 when empty. Pop on the clock edge when rd_en_i and rd_addr=0x10 and not empty.
- Unmapped reads return 0. Unmapped writes are ignored.
- TX FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE. Each bit lasts BAUD clocks; STOP lasts 1 or 2 bits.
- TX leaves IDLE when tx_en=1 and the FIFO is not empty; it pops the head into a shift register in the same cycle. LSB first.
- TX latency: TXDATA write at edge N → uart_tx low from edge N+2.
- Clearing tx_en mid-frame: the current frame completes and no further pops occur.
- From STOP, TX goes directly to START (back-to-back) if a next entry is available.
- tx_busy = FSM not IDLE.
- RX: 2-flop synchroniser; falling edge in IDLE with rx_en=1 → START.
- START: sample at BAUD/2 (floor). If the line is high (false start), return to IDLE. Otherwise, sample each following bit every BAUD clocks.
- RX collects dbits data bits, then parity if enabled, then one stop bit. Only one stop bit is checked regardless of CTRL[4].
- Parity mismatch sets parity_err. Stop bit = 0 sets frame_err. The word is still pushed in both cases.
- Push happens at the stop-bit sample. If the RX FIFO is full, the word is dropped and overrun is set. Push and pop in the same cycle on a full FIFO both succeed with no overrun.
- Clearing rx_en mid-frame: RX returns to IDLE immediately and the partial word is discarded.
- FIFOs: pointers one bit wider than log2(depth); wrap-around is exact. Simultaneous push and pop keeps the count unchanged.
- irq_o = (rxne_ie & !rx_empty) | (txe_ie & tx_empty) | overrun | parity_err | frame_err. Registered, so it follows its inputs by one cycle.

Test Plan:
1. Reset, BAUD=16, CTRL=0x101 (tx_en, 8N1), write TXDATA 0xA5 → uart_tx low at edge N+2, bits 1,0,1,0,0,1,0,1 at 16 clocks each, stop high; tx_busy deasserts after 160 clocks.
2. Loop uart_tx→uart_rx, CTRL=0x11B (tx_en, rx_en, odd parity, 2 stop), write 0x00,0xFF,0x3C → RXDATA reads 0x00,0xFF,0x3C; parity_err=0, frame_err=0; rx_empty=1 afterwards.
3. Write 17 bytes into TX_DEPTH=16 with tx_en=0 → tx_full=1 and the 17th is dropped; set tx_en → exactly 16 frames sent.
4. Drive 17 frames into RX without reads → rx_full=1, overrun=1, irq_o=1; first 16 words intact; W1C 0x10 to STATUS clears overrun.
5. Inject frame with stop=0 and even-parity error (CTRL parity=01) → word pushed, frame_err=1, parity_err=1; 1-clock low glitch on uart_rx → no start detected.
6. Assert rst_n_i mid TX DATA bit → uart_tx=1 asynchronously, STATUS=0x06, FIFOs empty.
